// File: rtl/i_cache_axi_rd_bridge_pkg.sv
// Shared AXI constants, FSM encoding and NOP instruction for the I-cache refill bridge.
package i_cache_axi_rd_bridge_pkg;

  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [2:0]  SIZE_4B    = 3'b010;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_AR    = 5'b00010,
    S_R     = 5'b00100,
    S_RESP  = 5'b01000,
    S_DRAIN = 5'b10000
  } state_t;

endpackage

// File: rtl/i_cache_axi_rd_bridge.sv
// I-cache refill responder: one single-beat AXI4 read per request, returns the addressed 32-bit word.
// All outputs registered; one outstanding transaction; an abandoned request still completes on AXI.
module i_cache_axi_rd_bridge
  import i_cache_axi_rd_bridge_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_read_ena,
  input  logic [ADDR_W-1:0] cache_addr,
  output logic [31:0]       cache_or_data,
  output logic              cache_in_ok,
  output logic              cache_rd_err,
  output logic              axi_ar_valid,
  input  logic              axi_ar_ready,
  output logic [ADDR_W-1:0] axi_ar_addr,
  output logic [ID_W-1:0]   axi_ar_id,
  output logic [7:0]        axi_ar_len,
  output logic [2:0]        axi_ar_size,
  output logic [1:0]        axi_ar_burst,
  input  logic              axi_r_valid,
  output logic              axi_r_ready,
  input  logic [DATA_W-1:0] axi_r_data,
  input  logic [1:0]        axi_r_resp,
  input  logic              axi_r_last,
  input  logic [ID_W-1:0]   axi_r_id
);

  localparam logic [ID_W-1:0] ARID = ID_W'(AXI_ID);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              ar_valid_q, ar_valid_d;
  logic              r_ready_q, r_ready_d;
  logic              in_ok_q, in_ok_d;
  logic              rd_err_q, rd_err_d;
  logic              err_q, err_d;
  logic              abort_q, abort_d;
  logic              abort_now;
  logic              beat;
  logic              resp_err;
  logic [31:0]       word;
  logic              unused_ok;

  assign abort_now = abort_q | ~cache_read_ena;
  assign beat      = axi_r_valid & r_ready_q & (axi_r_id == ARID);
  assign resp_err  = (axi_r_resp != RESP_OKAY);
  assign word      = addr_q[2] ? axi_r_data[63:32] : axi_r_data[31:0];
  assign unused_ok = ^addr_q[1:0];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    in_ok_d    = 1'b0;
    rd_err_d   = 1'b0;
    err_d      = err_q;
    abort_d    = abort_q;
    case (state_q)
      S_IDLE: begin
        // in_ok_q still high means the requester has not yet seen the previous word
        if (cache_read_ena && !in_ok_q) begin
          addr_d     = cache_addr;
          ar_valid_d = 1'b1;
          abort_d    = 1'b0;
          state_d    = S_AR;
        end
      end
      S_AR: begin
        if (!cache_read_ena) abort_d = 1'b1;
        if (axi_ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = S_R;
        end
      end
      S_R: begin
        if (!cache_read_ena) abort_d = 1'b1;
        if (beat) begin
          data_d = resp_err ? NOP_INSN : word;
          err_d  = resp_err;
          if (axi_r_last) begin
            r_ready_d = 1'b0;
            abort_d   = 1'b0;
            state_d   = abort_now ? S_IDLE : S_RESP;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!cache_read_ena) abort_d = 1'b1;
        if (axi_r_valid && r_ready_q && axi_r_last) begin
          r_ready_d = 1'b0;
          abort_d   = 1'b0;
          state_d   = abort_now ? S_IDLE : S_RESP;
        end
      end
      S_RESP: begin
        in_ok_d  = 1'b1;
        rd_err_d = err_q;
        abort_d  = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      in_ok_q    <= 1'b0;
      rd_err_q   <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      in_ok_q    <= in_ok_d;
      rd_err_q   <= rd_err_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
    end
  end

  assign cache_or_data = data_q;
  assign cache_in_ok   = in_ok_q;
  assign cache_rd_err  = rd_err_q;
  assign axi_ar_valid  = ar_valid_q;
  assign axi_ar_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign axi_ar_id     = ARID;
  assign axi_ar_len    = 8'd0;
  assign axi_ar_size   = SIZE_4B;
  assign axi_ar_burst  = BURST_INCR;
  assign axi_r_ready   = r_ready_q;

endmodule

// File: tb/tb_i_cache_axi_rd_bridge.sv
// Directed bench for the I-cache AXI read bridge with a cycle-accurate reactive AXI slave.
module tb_i_cache_axi_rd_bridge;

  logic        clk;
  logic        rst;
  logic        cache_read_ena;
  logic [63:0] cache_addr;
  logic [31:0] cache_or_data;
  logic        cache_in_ok;
  logic        cache_rd_err;
  logic        axi_ar_valid;
  logic        axi_ar_ready;
  logic [63:0] axi_ar_addr;
  logic [3:0]  axi_ar_id;
  logic [7:0]  axi_ar_len;
  logic [2:0]  axi_ar_size;
  logic [1:0]  axi_ar_burst;
  logic        axi_r_valid;
  logic        axi_r_ready;
  logic [63:0] axi_r_data;
  logic [1:0]  axi_r_resp;
  logic        axi_r_last;
  logic [3:0]  axi_r_id;

  int checks   = 0;
  int failures = 0;

  i_cache_axi_rd_bridge dut (
    .clk(clk), .rst(rst),
    .cache_read_ena(cache_read_ena), .cache_addr(cache_addr),
    .cache_or_data(cache_or_data), .cache_in_ok(cache_in_ok), .cache_rd_err(cache_rd_err),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
    .axi_ar_id(axi_ar_id), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
    .axi_ar_burst(axi_ar_burst),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_data(axi_r_data),
    .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last), .axi_r_id(axi_r_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one request for a fixed 20-cycle window; inputs change and outputs are sampled on negedges.
  // Cycle n is the state after the n-th rising edge following the request being raised.
  task automatic run_txn(input logic [63:0] addr, input int ar_wait, input int r_wait,
                         input logic [63:0] rdata, input logic [1:0] resp, input int drop_at,
                         output int ok_cyc, output logic [31:0] data, output logic err_seen,
                         output int ok_cnt, output int ar_hs, output logic ar_stable,
                         output logic [63:0] ar_addr_seen, output int r_hs);
    int   ar_cnt = 0;
    int   r_cnt = 0;
    logic ar_pend = 0, ar_done = 0, ar_seen = 0;
    logic r_pend = 0, r_done = 0;
    ok_cyc = -1; data = '0; err_seen = 0; ok_cnt = 0; ar_hs = 0; ar_stable = 1;
    ar_addr_seen = '0; r_hs = 0;
    cache_addr     = addr;
    cache_read_ena = 1'b1;
    axi_r_data     = rdata;
    axi_r_resp     = resp;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == drop_at) cache_read_ena = 1'b0;
      if (cache_in_ok) begin
        ok_cnt++;
        ok_cyc   = cyc;
        data     = cache_or_data;
        err_seen = cache_rd_err;
        cache_read_ena = 1'b0;
      end
      if (ar_pend) begin
        axi_ar_ready = 1'b0;
        ar_pend = 0;
        ar_done = 1;
      end
      if (ar_seen && !ar_done && !axi_ar_valid) ar_stable = 0;
      if (axi_ar_valid) begin
        if (!ar_seen) ar_addr_seen = axi_ar_addr;
        else if (axi_ar_addr !== ar_addr_seen) ar_stable = 0;
        ar_seen = 1;
        ar_cnt++;
        if (ar_cnt > ar_wait) begin
          axi_ar_ready = 1'b1;
          ar_hs++;
          ar_pend = 1;
        end
      end
      if (r_pend) begin
        axi_r_valid = 1'b0;
        r_pend = 0;
        r_done = 1;
      end
      if (!r_done && !r_pend && axi_r_ready) begin
        r_cnt++;
        if (r_cnt > r_wait) begin
          axi_r_valid = 1'b1;
          r_hs++;
          r_pend = 1;
        end
      end
    end
    cache_read_ena = 1'b0;
    axi_ar_ready   = 1'b0;
    axi_r_valid    = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks += 5;
    if (axi_ar_valid !== 1'b0) begin failures++; $display("FAIL reset_ar_valid got=%b want=0", axi_ar_valid); end
    if (axi_r_ready !== 1'b0) begin failures++; $display("FAIL reset_r_ready got=%b want=0", axi_r_ready); end
    if (cache_in_ok !== 1'b0) begin failures++; $display("FAIL reset_in_ok got=%b want=0", cache_in_ok); end
    if (cache_rd_err !== 1'b0) begin failures++; $display("FAIL reset_rd_err got=%b want=0", cache_rd_err); end
    if (cache_or_data !== 32'h0) begin failures++; $display("FAIL reset_or_data got=%h want=0", cache_or_data); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_hit();
    int oc, cnt, ah, rh; logic [31:0] d; logic e, st; logic [63:0] aa;
    run_txn(64'h8000_0004, 0, 0, 64'hDEAD_BEEF_1234_5678, 2'b00, -1, oc, d, e, cnt, ah, st, aa, rh);
    checks += 9;
    if (aa !== 64'h8000_0004) begin failures++; $display("FAIL hit_ar_addr got=%h want=8000_0004", aa); end
    if (axi_ar_len !== 8'd0) begin failures++; $display("FAIL hit_ar_len got=%h want=0", axi_ar_len); end
    if (axi_ar_size !== 3'b010) begin failures++; $display("FAIL hit_ar_size got=%b want=010", axi_ar_size); end
    if (axi_ar_burst !== 2'b01 || axi_ar_id !== 4'd0) begin failures++; $display("FAIL hit_ar_burst_id got=%b/%h want=01/0", axi_ar_burst, axi_ar_id); end
    if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL hit_data got=%h want=deadbeef", d); end
    if (oc !== 4) begin failures++; $display("FAIL hit_latency got=%0d want=4", oc); end
    if (cnt !== 1) begin failures++; $display("FAIL hit_in_ok_count got=%0d want=1", cnt); end
    if (e !== 1'b0) begin failures++; $display("FAIL hit_rd_err got=%b want=0", e); end
    if (ah !== 1) begin failures++; $display("FAIL hit_ar_hs got=%0d want=1", ah); end
  endtask

  task automatic test_low_word();
    int oc, cnt, ah, rh; logic [31:0] d; logic e, st; logic [63:0] aa;
    run_txn(64'h8000_0000, 0, 0, 64'hDEAD_BEEF_1234_5678, 2'b00, -1, oc, d, e, cnt, ah, st, aa, rh);
    checks += 2;
    if (d !== 32'h1234_5678) begin failures++; $display("FAIL low_data got=%h want=12345678", d); end
    if (aa !== 64'h8000_0000) begin failures++; $display("FAIL low_ar_addr got=%h want=8000_0000", aa); end
  endtask

  task automatic test_ar_backpressure();
    int oc, cnt, ah, rh; logic [31:0] d; logic e, st; logic [63:0] aa;
    run_txn(64'h0000_1236, 5, 0, 64'hCAFE_F00D_0BAD_CAFE, 2'b00, -1, oc, d, e, cnt, ah, st, aa, rh);
    checks += 5;
    if (st !== 1'b1) begin failures++; $display("FAIL bp_ar_stable got=%b want=1", st); end
    if (ah !== 1) begin failures++; $display("FAIL bp_ar_hs got=%0d want=1", ah); end
    if (aa !== 64'h0000_1234) begin failures++; $display("FAIL bp_ar_addr got=%h want=1234", aa); end
    if (d !== 32'hCAFE_F00D) begin failures++; $display("FAIL bp_data got=%h want=cafef00d", d); end
    if (oc !== 9) begin failures++; $display("FAIL bp_latency got=%0d want=9", oc); end
  endtask

  task automatic test_error_resp();
    int oc, cnt, ah, rh; logic [31:0] d; logic e, st; logic [63:0] aa;
    run_txn(64'h8000_0004, 0, 0, 64'hDEAD_BEEF_1234_5678, 2'b10, -1, oc, d, e, cnt, ah, st, aa, rh);
    checks += 3;
    if (cnt !== 1) begin failures++; $display("FAIL err_in_ok_count got=%0d want=1", cnt); end
    if (e !== 1'b1) begin failures++; $display("FAIL err_rd_err got=%b want=1", e); end
    if (d !== 32'h0000_0013) begin failures++; $display("FAIL err_data got=%h want=00000013", d); end
  endtask

  task automatic test_abort();
    int oc, cnt, ah, rh; logic [31:0] d; logic e, st; logic [63:0] aa;
    run_txn(64'h0000_2000, 0, 3, 64'h1111_2222_3333_4444, 2'b00, 2, oc, d, e, cnt, ah, st, aa, rh);
    checks += 2;
    if (rh !== 1) begin failures++; $display("FAIL abort_r_hs got=%0d want=1", rh); end
    if (cnt !== 0) begin failures++; $display("FAIL abort_in_ok_count got=%0d want=0", cnt); end
    repeat (2) @(negedge clk);
    run_txn(64'h0000_2004, 0, 0, 64'h5555_6666_7777_8888, 2'b00, -1, oc, d, e, cnt, ah, st, aa, rh);
    checks += 3;
    if (d !== 32'h5555_6666) begin failures++; $display("FAIL abort_next_data got=%h want=55556666", d); end
    if (oc !== 4) begin failures++; $display("FAIL abort_next_latency got=%0d want=4", oc); end
    if (cnt !== 1) begin failures++; $display("FAIL abort_next_in_ok_count got=%0d want=1", cnt); end
  endtask

  task automatic test_reset_mid_r();
    int oc, cnt, ah, rh; logic [31:0] d; logic e, st; logic [63:0] aa;
    logic reached = 0;
    @(negedge clk);
    cache_addr     = 64'h0000_3000;
    cache_read_ena = 1'b1;
    axi_ar_ready   = 1'b1;
    for (int i = 0; i < 10 && !reached; i++) begin
      @(negedge clk);
      if (axi_r_ready) reached = 1;
    end
    axi_ar_ready = 1'b0;
    checks++;
    if (!reached) begin failures++; $display("FAIL rst_reach_r got=0 want=1"); end
    #2 rst = 1'b0;
    #1;
    checks += 3;
    if (axi_r_ready !== 1'b0 || axi_ar_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_axi got=%b%b want=00", axi_ar_valid, axi_r_ready); end
    if (cache_in_ok !== 1'b0 || cache_rd_err !== 1'b0) begin failures++; $display("FAIL rst_mid_cache got=%b%b want=00", cache_in_ok, cache_rd_err); end
    if (cache_or_data !== 32'h0) begin failures++; $display("FAIL rst_mid_data got=%h want=0", cache_or_data); end
    cache_read_ena = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_txn(64'h0000_3004, 0, 0, 64'h9999_AAAA_BBBB_CCCC, 2'b00, -1, oc, d, e, cnt, ah, st, aa, rh);
    checks += 3;
    if (ah !== 1) begin failures++; $display("FAIL rst_fresh_ar_hs got=%0d want=1", ah); end
    if (aa !== 64'h0000_3004) begin failures++; $display("FAIL rst_fresh_ar_addr got=%h want=3004", aa); end
    if (d !== 32'h9999_AAAA || oc !== 4) begin failures++; $display("FAIL rst_fresh_data got=%h@%0d want=9999aaaa@4", d, oc); end
  endtask

  initial begin
    rst = 1'b0;
    cache_read_ena = 1'b0;
    cache_addr   = '0;
    axi_ar_ready = 1'b0;
    axi_r_valid  = 1'b0;
    axi_r_data   = '0;
    axi_r_resp   = 2'b00;
    axi_r_last   = 1'b1;
    axi_r_id     = 4'd0;
    test_reset();
    test_single_hit();
    test_low_word();
    test_ar_backpressure();
    test_error_resp();
    test_abort();
    test_reset_mid_r();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i_cache_axi_rd_bridge.md
Name: i_cache_axi_rd_bridge

Overview:
- Responder for the instruction-cache refill interface (cache_read_ena / cache_addr / cache_or_data / cache_in_ok).
- Converts each refill request into one single-beat AXI4 read transaction on the instruction memory port, then returns the selected 32-bit word to the I-cache.
- Sits between i_cache1 and the AXI4 crossbar; read-only, one outstanding transaction.

Parameters:
- ADDR_W, 64, request and AXI address width.
- DATA_W, 64, AXI R data width.
- ID_W, 4, AXI ID width.
- AXI_ID, 0, fixed ARID driven on every request.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cache_read_ena  in  1  refill request, level; held high until cache_in_ok
- cache_addr  in  ADDR_W  refill byte address
- cache_or_data  out  32  returned instruction word
- cache_in_ok  out  1  one-cycle pulse, data valid
- cache_rd_err  out  1  one-cycle pulse with cache_in_ok when RRESP != OKAY
- axi_ar_valid  out  1  AR valid
- axi_ar_ready  in  1  AR ready
- axi_ar_addr  out  ADDR_W  {cache_addr[ADDR_W-1:2], 2'b00}
- axi_ar_id  out  ID_W  AXI_ID
- axi_ar_len  out  8  constant 0
- axi_ar_size  out  3  constant 3'b010
- axi_ar_burst  out  2  constant INCR (2'b01)
- axi_r_valid  in  1  R valid
- axi_r_ready  out  1  R ready
- axi_r_data  in  DATA_W  R data
- axi_r_resp  in  2  R response
- axi_r_last  in  1  R last
- axi_r_id  in  ID_W  R id

Behaviour:
- Reset (rst low, async): state IDLE.
- Reset values: axi_ar_valid=0, axi_r_ready=0, cache_in_ok=0, cache_rd_err=0, cache_or_data=0, latched address=0, abort flag=0.
- All outputs are registered.
- States: IDLE, AR, R, RESP, DRAIN.
- IDLE:
  - If cache_read_ena=1 and cache_in_ok=0, latch cache_addr into addr_q.
  - Next cycle: axi_ar_valid=1, go to AR.
  - Minimum request-to-ARVALID latency is 1 cycle.
- AR:
  - Hold axi_ar_valid and axi_ar_addr stable until axi_ar_ready=1; never drop ARVALID before the handshake.
  - On handshake: axi_ar_valid=0, axi_r_ready=1, go to R.
- R:
  - On axi_r_valid & axi_r_ready with matching axi_r_id: capture word = addr_q[2] ? r_data[63:32] : r_data[31:0] (for DATA_W=64).
  - err = (r_resp != 2'b00); on err the captured word is forced to 32'h0000_0013 (NOP) and cache_rd_err pulses.
  - axi_r_ready=0, go to RESP.
  - r_last is expected high; if it is low, keep r_ready=1 and discard further beats until the last beat.
  - R beats with a mismatched ID are accepted and ignored.
- RESP:
  - cache_in_ok=1 for exactly one cycle with cache_or_data valid, then go to IDLE.
  - cache_or_data holds its value until the next capture.
  - Minimum request-to-in_ok latency with zero-wait AXI is 4 cycles.
- Back-to-back requests:
  - In the cycle after the in_ok pulse, IDLE re-samples cache_read_ena.
  - The requester must drop cache_read_ena combinationally on cache_in_ok; a request still high in the next cycle is treated as a new request.
- Abort:
  - If cache_read_ena falls while in AR or R, set the abort flag.
  - The AXI transaction always completes; it is never cancelled mid-handshake.
  - On completion with abort set, suppress cache_in_ok/cache_rd_err, go to IDLE, clear the flag.
- DRAIN: used only for the r_last=0 case. Stay with r_ready=1 until the r_last beat, then go to RESP (or to IDLE if aborted).
- Async reset mid-transaction: return to IDLE immediately. The interconnect is reset by the same rst, so no orphan response is handled.
- No simultaneous request and response is possible, because there is only one outstanding transaction.

Decomposition:
- Shared package/defines (extend defines_axi4.v):
  - AXI constants: RESP_OKAY=2'b00, BURST_INCR=2'b01, SIZE_4B=3'b010.
  - FSM state encodings: one-hot, 5 bits.
  - NOP encoding constant.
- No sub-module; single flat module. Word-select logic is inline.

Test Plan:
- Single hit path:
  - Stimulus: cache_addr=64'h8000_0004, read_ena=1; AR ready immediate; R returns r_data=64'hDEAD_BEEF_1234_5678, resp=0, last=1.
  - Required: ar_addr=64'h8000_0004, len=0, size=3'b010; cache_or_data=32'hDEAD_BEEF; one in_ok pulse at cycle 4.
- Low-word select:
  - Stimulus: addr 64'h8000_0000 with the same R data.
  - Required: cache_or_data=32'h1234_5678.
- AR backpressure:
  - Stimulus: ar_ready held low 5 cycles.
  - Required: ar_valid held 1 and ar_addr stable throughout; exactly one AR handshake.
- Error response:
  - Stimulus: r_resp=2'b10.
  - Required: cache_in_ok=1 and cache_rd_err=1 in the same cycle; cache_or_data=32'h0000_0013.
- Abort:
  - Stimulus: drop read_ena after the AR handshake; R arrives 3 cycles later.
  - Required: r_ready handshake occurs, no in_ok pulse; a new request 2 cycles later completes normally.
- Reset mid-R:
  - Stimulus: rst low while in R.
  - Required: all outputs 0 asynchronously; after release, a new request issues a fresh AR.
